// File: rtl/sqrwav_pkg.sv
// Shared types and defaults for the square-wave period meter.
package sqrwav_pkg;

  localparam int METER_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } meter_state_t;

endpackage

// File: rtl/sqrwav_meter_edge_det.sv
// Edge detector for the metered wave; SQRWAV_METER_SYNC_EN inserts a 2-flop synchronizer
// (adds 2 cycles of latency, widths unchanged). No backpressure: samples every cycle.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic wave_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic wave_d;

`ifdef SQRWAV_METER_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], wave_in};
    end
  end

  assign s = sync[1];
`else
  assign s = wave_in;
`endif

  // wave_d resets low, so a wave already high at reset shows up as a rise, never a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wave_d <= 1'b0;
    end else begin
      wave_d <= s;
    end
  end

  assign rise = s & ~wave_d;
  assign fall = ~s & wave_d;

endmodule

// File: rtl/sqrwav_meter.sv
// Measures high/low phase widths of each full period; results 1 cycle after the closing rise
// (3 with SQRWAV_METER_SYNC_EN). No backpressure: valid is a one-cycle strobe, outputs hold.
module sqrwav_meter
  import sqrwav_pkg::*;
#(
  parameter int W = METER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         wave_in,
  output logic [W-1:0] high_cnt,
  output logic [W-1:0] low_cnt,
  output logic [W:0]   period_cnt,
  output logic         valid,
  output logic         ovf,
  output logic         stuck
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] ONE     = W'(1);

  meter_state_t state;
  logic [W-1:0] cnt;
  logic [W-1:0] high_q;
  logic [W-1:0] cnt_inc;
  logic         phase_sat;
  logic         at_max;
  logic         rise;
  logic         fall;
  logic         s_unused;

  edge_det u_edge_det (
    .clk     (clk),
    .rst     (rst),
    .wave_in (wave_in),
    .s       (s_unused),
    .rise    (rise),
    .fall    (fall)
  );

  assign at_max  = (cnt == CNT_MAX);
  assign cnt_inc = at_max ? cnt : cnt + ONE;
  assign stuck   = ((state == MEAS_HIGH) || (state == MEAS_LOW)) && at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      high_q     <= '0;
      phase_sat  <= 1'b0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period_cnt <= '0;
      valid      <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        cnt       <= '0;
        phase_sat <= 1'b0;
      end else begin
        case (state)
          // Wait for a fall so the partial period at reset/enable is never measured.
          IDLE: begin
            if (fall) begin
              state <= ARMED;
            end
          end
          ARMED: begin
            if (rise) begin
              state <= MEAS_HIGH;
              cnt   <= ONE;
            end
          end
          MEAS_HIGH: begin
            if (fall) begin
              high_q <= cnt;
              cnt    <= ONE;
              state  <= MEAS_LOW;
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc == CNT_MAX) begin
                phase_sat <= 1'b1;
              end
            end
          end
          MEAS_LOW: begin
            if (rise) begin
              high_cnt   <= high_q;
              low_cnt    <= cnt;
              period_cnt <= {1'b0, high_q} + {1'b0, cnt};
              ovf        <= phase_sat;
              valid      <= 1'b1;
              phase_sat  <= 1'b0;
              cnt        <= ONE;
              state      <= MEAS_HIGH;
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc == CNT_MAX) begin
                phase_sat <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sqrwav_meter.sv
// Scoreboard bench: a phase-level model pushes expected periods; two DUTs (W=16, W=4) share stimulus.
// Build with SQRWAV_METER_SYNC_EN defined to cover the synchronized input path.
module tb_sqrwav_meter;
  import sqrwav_pkg::*;

`ifdef SQRWAV_METER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int hi;
    int lo;
    int per;
    int ovf;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic wave_in;

  logic [15:0] high_cnt, low_cnt;
  logic [16:0] period_cnt;
  logic        valid, ovf, stuck;
  logic [3:0]  h4, l4;
  logic [4:0]  p4;
  logic        v4, o4, s4;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  exp_t q16[$];
  exp_t q4[$];
  exp_t e16, e4;
  int   last_hi16, last_lo16, last_hi4;

  // phase-level reference model
  int   m_st;   // 0 idle, 1 armed, 2 high, 3 low
  logic m_prev;
  logic m_en;
  int   m_len;
  int   m_hi;

  sqrwav_meter #(.W(16)) u16 (
    .clk(clk), .rst(rst), .en(en), .wave_in(wave_in),
    .high_cnt(high_cnt), .low_cnt(low_cnt), .period_cnt(period_cnt),
    .valid(valid), .ovf(ovf), .stuck(stuck)
  );

  sqrwav_meter #(.W(4)) u4 (
    .clk(clk), .rst(rst), .en(en), .wave_in(wave_in),
    .high_cnt(h4), .low_cnt(l4), .period_cnt(p4),
    .valid(v4), .ovf(o4), .stuck(s4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic push_period(input int hl, input int ll);
    exp_t e;
    e.hi  = sat(hl, 65535);
    e.lo  = sat(ll, 65535);
    e.per = e.hi + e.lo;
    e.ovf = ((hl >= 65535) || (ll >= 65535)) ? 1 : 0;
    e.cyc = cyc + LAT;
    q16.push_back(e);
    e.hi  = sat(hl, 15);
    e.lo  = sat(ll, 15);
    e.per = e.hi + e.lo;
    e.ovf = ((hl >= 15) || (ll >= 15)) ? 1 : 0;
    q4.push_back(e);
  endtask

  // Drive v for n cycles, advancing the model on the edge that opens this phase.
  task automatic phase(input logic v, input int n);
    if (v != m_prev) begin
      if (m_en) begin
        case (m_st)
          0: if (!v) m_st = 1;
          1: if (v) m_st = 2;
          2: if (!v) begin m_hi = m_len; m_st = 3; end
          3: if (v) begin push_period(m_hi, m_len); m_st = 2; end
          default: m_st = 0;
        endcase
      end
      m_len = 0;
    end
    m_len  += n;
    m_prev = v;
    wave_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_en(input logic v);
    en   = v;
    m_en = v;
    if (!v) m_st = 0;
  endtask

  task automatic model_reset();
    m_st   = 0;
    m_prev = 1'b0;
    m_len  = 0;
    m_hi   = 0;
  endtask

  always @(negedge clk) begin
    if (valid) begin
      chk("m16_pending", q16.size() > 0, 1);
      if (q16.size() > 0) begin
        e16 = q16.pop_front();
        chk("m16_high", high_cnt, e16.hi);
        chk("m16_low", low_cnt, e16.lo);
        chk("m16_period", period_cnt, e16.per);
        chk("m16_ovf", ovf, e16.ovf);
        chk("m16_cycle", cyc, e16.cyc);
        last_hi16 = e16.hi;
        last_lo16 = e16.lo;
      end
    end
    if (v4) begin
      chk("m4_pending", q4.size() > 0, 1);
      if (q4.size() > 0) begin
        e4 = q4.pop_front();
        chk("m4_high", h4, e4.hi);
        chk("m4_low", l4, e4.lo);
        chk("m4_period", p4, e4.per);
        chk("m4_ovf", o4, e4.ovf);
        chk("m4_cycle", cyc, e4.cyc);
        last_hi4 = e4.hi;
      end
    end
  end

  initial begin
    rst     = 1'b1;
    en      = 1'b1;
    m_en    = 1'b1;
    wave_in = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_high", high_cnt, 0);
    chk("rst_low", low_cnt, 0);
    chk("rst_period", period_cnt, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_state", u16.state, IDLE);
    rst = 1'b0;

    // wave high across reset, a low pulse, then 3/2 periods
    phase(1, 3);
    phase(0, 2);
    repeat (4) begin
      phase(1, 3);
      phase(0, 2);
    end

    // minimum 1/1 periods
    repeat (6) begin
      phase(1, 1);
      phase(0, 1);
    end

    // 20-cycle high phase saturates the W=4 counter at its 15th sample
    phase(1, 13 + LAT);
    chk("stuck4_pre", s4, 0);
    chk("stuck16_pre", stuck, 0);
    phase(1, 1);
    chk("stuck4_at15", s4, 1);
    chk("stuck16_at15", stuck, 0);
    phase(1, 6 - LAT);
    chk("stuck4_held", s4, 1);
    phase(0, 3);
    chk("stuck4_cleared", s4, 0);
    phase(1, 3);
    phase(0, 3);
    phase(1, 3);

    // en dropped mid low phase, re-raised mid another low phase
    phase(0, 3);
    set_en(1'b0);
    phase(0, 3);
    phase(1, 4);
    phase(0, 4);
    set_en(1'b1);
    phase(0, 3);
    phase(1, 4);
    phase(0, 4);
    phase(1, 3);
    phase(0, 2);
    chk("hold_high16", high_cnt, last_hi16);
    chk("hold_low16", low_cnt, last_lo16);
    chk("hold_high4", h4, last_hi4);
    phase(1, 3);

`ifndef SQRWAV_METER_SYNC_EN
    // en falls on the same edge as the closing rise: nothing published
    phase(0, 2);
    set_en(1'b0);
    phase(1, 3);
    set_en(1'b1);
    phase(0, 2);
    phase(1, 2);
    phase(0, 2);
    phase(1, 2);
`endif

    // asynchronous reset in the middle of a high phase
    phase(0, 2);
    phase(1, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_high", high_cnt, 0);
    chk("arst_low", low_cnt, 0);
    chk("arst_period", period_cnt, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_stuck", stuck, 0);
    chk("arst_high4", h4, 0);
    chk("arst_state", u16.state, IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    phase(1, 2);
    phase(0, 2);
    repeat (3) begin
      phase(1, 3);
      phase(0, 2);
    end
    phase(1, 3);
    phase(0, 4);

    chk("q16_drained", q16.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
